// File: rtl/cmp_pkg.sv
// Shared constants for the comparison-flag consumer: condition codes, FSM encoding, flag bit positions.
package cmp_pkg;

   localparam int COND_EQ       = 0;
   localparam int COND_NE       = 1;
   localparam int COND_GT       = 2;
   localparam int COND_GE       = 3;
   localparam int COND_LT       = 4;
   localparam int COND_LE       = 5;
   localparam int COND_AL       = 6;
   localparam int COND_NV       = 7;
   localparam int COND_RSVD_MIN = 8;

   localparam int FLAG_GT = 2;
   localparam int FLAG_LT = 1;
   localparam int FLAG_ET = 0;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOADED = 2'd1,
      ST_BUSY   = 2'd2
   } st_t;

endpackage

// File: rtl/cmp_cond_decode.sv
// Combinational condition evaluator: (flags, flag_err, cond) -> (taken, err).
// Reserved codes and malformed flags both force taken low; AL/NV never look at the flags.
module cmp_cond_decode
   import cmp_pkg::*;
#(
   parameter int COND_W = 4
) (
   input  logic [2:0]        i_flags,
   input  logic              i_flag_err,
   input  logic [COND_W-1:0] i_cond,
   output logic              o_taken,
   output logic              o_err
);

   logic w_tk;
   logic w_rsvd;
   logic w_uncond;

   always_comb begin
      w_tk     = 1'b0;
      w_rsvd   = 1'b0;
      w_uncond = 1'b0;
      case (i_cond)
         COND_W'(COND_EQ): w_tk = i_flags[FLAG_ET];
         COND_W'(COND_NE): w_tk = ~i_flags[FLAG_ET];
         COND_W'(COND_GT): w_tk = i_flags[FLAG_GT];
         COND_W'(COND_GE): w_tk = i_flags[FLAG_GT] | i_flags[FLAG_ET];
         COND_W'(COND_LT): w_tk = i_flags[FLAG_LT];
         COND_W'(COND_LE): w_tk = i_flags[FLAG_LT] | i_flags[FLAG_ET];
         COND_W'(COND_AL): begin
            w_tk     = 1'b1;
            w_uncond = 1'b1;
         end
         COND_W'(COND_NV): w_uncond = 1'b1;
         default:          w_rsvd = 1'b1;
      endcase
   end

   assign o_err   = w_rsvd | (i_flag_err & ~w_uncond);
   assign o_taken = w_tk & ~o_err;

endmodule

// File: rtl/cmp_cond_eval.sv
// Stores one GT/LT/ET triple per handshake and answers condition requests against it.
// Result registered on the accepting edge and held until res_ready; saturating taken counter.
module cmp_cond_eval
   import cmp_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int COND_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flag_valid,
   output logic              flag_ready,
   input  logic              GT,
   input  logic              LT,
   input  logic              ET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [COND_W-1:0] req_cond,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_taken,
   output logic              res_err,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  taken_cnt
);

   st_t              r_state;
   logic [2:0]       r_flags;
   logic             r_flag_err;
   logic             r_taken;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic [2:0] w_flags_in;
   logic       w_onehot;
   logic       w_flag_xfer;
   logic       w_req_xfer;
   logic       w_res_xfer;
   logic       w_dec_taken;
   logic       w_dec_err;

   assign w_flags_in[FLAG_GT] = GT;
   assign w_flags_in[FLAG_LT] = LT;
   assign w_flags_in[FLAG_ET] = ET;
   assign w_onehot = (w_flags_in == 3'b100) | (w_flags_in == 3'b010) | (w_flags_in == 3'b001);

   // Handshake outputs decode state only, so no input reaches them combinationally.
   assign flag_ready = (r_state != ST_BUSY);
   assign req_ready  = (r_state == ST_LOADED);
   assign res_valid  = (r_state == ST_BUSY);
   assign res_taken  = r_taken;
   assign res_err    = r_err;
   assign taken_cnt  = r_cnt;

   assign w_flag_xfer = flag_valid & flag_ready;
   assign w_req_xfer  = req_valid & req_ready;
   assign w_res_xfer  = res_valid & res_ready;

   // Evaluated against the stored flags, so a same-cycle flag load affects only later requests.
   cmp_cond_decode #(.COND_W(COND_W)) u_dec (
      .i_flags    (r_flags),
      .i_flag_err (r_flag_err),
      .i_cond     (req_cond),
      .o_taken    (w_dec_taken),
      .o_err      (w_dec_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_flags    <= 3'b000;
         r_flag_err <= 1'b0;
         r_taken    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_flag_xfer) begin
            r_flags    <= w_flags_in;
            r_flag_err <= ~w_onehot;
         end
         if (w_req_xfer) begin
            r_taken <= w_dec_taken;
            r_err   <= w_dec_err;
         end
         case (r_state)
            ST_EMPTY:  if (w_flag_xfer) r_state <= ST_LOADED;
            ST_LOADED: if (w_req_xfer)  r_state <= ST_BUSY;
            ST_BUSY:   if (w_res_xfer)  r_state <= ST_LOADED;
            default:   r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_res_xfer & r_taken & ~(&r_cnt)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cmp_cond_eval.sv
// Directed and random stimulus against a transaction-level model of the flag/condition unit.
module tb_cmp_cond_eval;

   localparam int CNT_W   = 3;
   localparam int COND_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              flag_valid;
   logic              flag_ready;
   logic              GT, LT, ET;
   logic              req_valid;
   logic              req_ready;
   logic [COND_W-1:0] req_cond;
   logic              res_valid;
   logic              res_ready;
   logic              res_taken;
   logic              res_err;
   logic              cnt_clr;
   logic [CNT_W-1:0]  taken_cnt;

   int total = 0;
   int bad   = 0;

   bit         m_have, m_busy, m_taken, m_err;
   int         m_cnt;
   logic [2:0] m_flags;

   always #5 clk = ~clk;

   cmp_cond_eval #(.CNT_W(CNT_W), .COND_W(COND_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flag_valid (flag_valid),
      .flag_ready (flag_ready),
      .GT         (GT),
      .LT         (LT),
      .ET         (ET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cond   (req_cond),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_taken  (res_taken),
      .res_err    (res_err),
      .cnt_clr    (cnt_clr),
      .taken_cnt  (taken_cnt)
   );

   // Conditions as relations on the signed ordering of the compared operands.
   function automatic void ref_eval(input logic [2:0] f, input int c, output bit tk, output bit er);
      int rel;
      tk = 1'b0;
      er = 1'b0;
      if (c >= 8) begin
         er = 1'b1;
      end else if (c == 6) begin
         tk = 1'b1;
      end else if (c == 7) begin
         tk = 1'b0;
      end else if ($countones(f) != 1) begin
         er = 1'b1;
      end else begin
         rel = f[2] ? 1 : (f[1] ? -1 : 0);
         case (c)
            0: tk = (rel == 0);
            1: tk = (rel != 0);
            2: tk = (rel > 0);
            3: tk = (rel >= 0);
            4: tk = (rel < 0);
            default: tk = (rel <= 0);
         endcase
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_have  = 1'b0;
      m_busy  = 1'b0;
      m_taken = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_flags = 3'b000;
   endtask

   task automatic check_outputs();
      chk("flag_ready", {31'd0, flag_ready}, {31'd0, !m_busy});
      chk("req_ready",  {31'd0, req_ready},  {31'd0, m_have && !m_busy});
      chk("res_valid",  {31'd0, res_valid},  {31'd0, m_busy});
      chk("taken_cnt",  {29'd0, taken_cnt},  m_cnt);
      if (m_busy) begin
         chk("res_taken", {31'd0, res_taken}, {31'd0, m_taken});
         chk("res_err",   {31'd0, res_err},   {31'd0, m_err});
      end
   endtask

   task automatic step(input bit fv, input logic [2:0] f, input bit rv, input int c,
                       input bit rr, input bit clr);
      bit a_res, a_req, a_flag;
      flag_valid = fv;
      {GT, LT, ET} = f;
      req_valid = rv;
      req_cond  = c[COND_W-1:0];
      res_ready = rr;
      cnt_clr   = clr;
      check_outputs();
      @(posedge clk);
      a_res  = m_busy && rr;
      a_req  = rv && m_have && !m_busy;
      a_flag = fv && !m_busy;
      if (clr) m_cnt = 0;
      else if (a_res && m_taken && m_cnt < CNT_MAX) m_cnt++;
      if (a_req) begin
         ref_eval(m_flags, c, m_taken, m_err);
         m_busy = 1'b1;
      end
      if (a_res) m_busy = 1'b0;
      if (a_flag) begin
         m_flags = f;
         m_have  = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      mreset();
      chk("rst_res_valid",  {31'd0, res_valid},  32'd0);
      chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
      chk("rst_flag_ready", {31'd0, flag_ready}, 32'd1);
      chk("rst_taken_cnt",  {29'd0, taken_cnt},  32'd0);
      chk("rst_res_taken",  {31'd0, res_taken},  32'd0);
      chk("rst_res_err",    {31'd0, res_err},    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic request(input int c);
      step(1'b0, 3'b000, 1'b1, c, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [7:0] seq;
      bit fv, rv, rr, clr;
      logic [2:0] f;
      int c;

      rst = 1'b1;
      flag_valid = 1'b0;
      {GT, LT, ET} = 3'b000;
      req_valid = 1'b0;
      req_cond = '0;
      res_ready = 1'b0;
      cnt_clr = 1'b0;
      mreset();
      @(posedge clk);
      #1;
      do_reset();

      // Requests while EMPTY are never accepted.
      repeat (3) step(1'b0, 3'b000, 1'b1, 6, 1'b1, 1'b0);

      // GT loaded, all unreserved codes back-to-back.
      seq = 8'b0100_1110;
      step(1'b1, 3'b100, 1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 3'b000, 1'b1, k, 1'b1, 1'b0);
         chk("gt_seq_taken", {31'd0, res_taken}, {31'd0, seq[k]});
         chk("gt_seq_err",   {31'd0, res_err},   32'd0);
         step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
      end
      chk("cnt_after_seq", {29'd0, taken_cnt}, 32'd4);

      // Result held under backpressure; flags offered while BUSY are ignored.
      step(1'b1, 3'b001, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 3, 1'b0, 1'b0);
      repeat (5) step(1'b1, 3'b100, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
      request(0);

      // Simultaneous flag load and request.
      step(1'b1, 3'b010, 1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 3'b100, 1'b1, 4, 1'b0, 1'b0);
      chk("old_flags_lt", {31'd0, res_taken}, 32'd1);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 3'b000, 1'b1, 2, 1'b0, 1'b0);
      chk("new_flags_gt", {31'd0, res_taken}, 32'd1);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);

      // Malformed flags and reserved codes.
      step(1'b1, 3'b011, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 0, 1'b0, 1'b0);
      chk("malformed_eq_err", {31'd0, res_err}, 32'd1);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 3'b000, 1'b1, 6, 1'b0, 1'b0);
      chk("malformed_al_taken", {31'd0, res_taken}, 32'd1);
      chk("malformed_al_err",   {31'd0, res_err},   32'd0);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 3'b100, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 9, 1'b0, 1'b0);
      chk("reserved_err", {31'd0, res_err}, 32'd1);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b0);

      // Saturation, clear priority, reset while BUSY.
      repeat (9) request(6);
      chk("cnt_saturated", {29'd0, taken_cnt}, CNT_MAX);
      step(1'b0, 3'b000, 1'b1, 6, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 0, 1'b1, 1'b1);
      chk("clr_priority", {29'd0, taken_cnt}, 32'd0);
      step(1'b0, 3'b000, 1'b1, 6, 1'b0, 1'b0);
      chk("busy_before_rst", {31'd0, res_valid}, 32'd1);
      do_reset();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         fv  = ($urandom_range(0, 2) == 0);
         f   = ($urandom_range(0, 1) == 0) ? (3'b001 << $urandom_range(0, 2))
                                          : 3'($urandom_range(0, 7));
         rv  = ($urandom_range(0, 1) == 0);
         c   = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
         rr  = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 31) == 0);
         step(fv, f, rv, c, rr, clr);
         if (i == 300) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_cond_eval.md
Name: cmp_cond_eval

Overview:
- Consumer end of the comparison unit's GT/LT/ET flag interface.
- Captures one flag triple per valid/ready transfer into a flag register.
- Answers branch/select condition requests against the stored flags: taken/not-taken result plus error indication, returned over a valid/ready channel.
- Keeps a saturating count of taken results for the ALU status block.

Parameters:
- CNT_W, 16, width of the taken-result counter.
- COND_W, 4, width of the condition-code field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flag_valid  input  1  producer presents a flag triple.
- flag_ready  output  1  block can accept a flag triple.
- GT  input  1  greater-than flag from the comparison unit.
- LT  input  1  less-than flag.
- ET  input  1  equal flag.
- req_valid  input  1  condition request present.
- req_ready  output  1  block accepts the request this cycle.
- req_cond  input  COND_W  condition code.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_taken  output  1  condition true.
- res_err  output  1  flags malformed or condition code reserved.
- cnt_clr  input  1  synchronous clear of taken_cnt.
- taken_cnt  output  CNT_W  saturating count of accepted results with res_taken=1.

Behaviour:
- Reset: state=EMPTY; flag register=000; flag_err=0; res_valid=0; res_taken=0; res_err=0; taken_cnt=0. Reset mid-transaction discards any pending result and the stored flags.
- FSM states and handshake outputs:
  - EMPTY: flag_ready=1, req_ready=0.
  - LOADED: flag_ready=1, req_ready=1.
  - BUSY: flag_ready=0, req_ready=0, res_valid=1.
- Transitions:
  - EMPTY -> LOADED on a flag transfer.
  - LOADED -> BUSY on a request transfer.
  - BUSY -> LOADED when res_valid & res_ready.
- Flag capture: on flag_valid & flag_ready, register {GT,LT,ET}.
  - flag_err = triple is not exactly one-hot (000, 011, 111, ...). Malformed flags are still stored.
- Simultaneous flag transfer and request in LOADED: the request is evaluated against the previously stored flags; the new flags are stored in the same edge.
- Latency: request accepted at edge N; result registered at edge N; res_valid high during cycle N+1. Result is held stable until res_ready.
- Condition codes:
  - 0 EQ: ET
  - 1 NE: !ET
  - 2 GT: GT
  - 3 GE: GT|ET
  - 4 LT: LT
  - 5 LE: LT|ET
  - 6 AL: 1
  - 7 NV: 0
  - 8-15 reserved: res_err=1, res_taken=0.
- If flag_err=1, any code other than AL/NV gives res_err=1, res_taken=0. AL/NV ignore flag_err.
- taken_cnt: increments on res_valid & res_ready & res_taken; saturates at all-ones (no wrap). cnt_clr has priority over a coincident increment, giving 0.
- No combinational path from any input to any ready/valid output; all handshake outputs are decoded from registered state only.

Decomposition:
- Shared package cmp_pkg:
  - condition-code localparams: COND_EQ..COND_NV, COND_RSVD_MIN=8.
  - FSM state encoding: ST_EMPTY, ST_LOADED, ST_BUSY.
  - flag index constants: FLAG_GT=2, FLAG_LT=1, FLAG_ET=0.
- One natural sub-module: cmp_cond_decode.
  - Purely combinational: (flags, flag_err, cond) -> (taken, err).
  - Instantiated once; reusable by the branch unit.

Test Plan:
- Reset then req_valid=1 cond=6 -> req_ready stays 0 (EMPTY); res_valid=0, taken_cnt=0.
- Load GT=1,LT=0,ET=0; request codes 0..7 back-to-back with res_ready=1 -> taken sequence 0,1,1,1,0,0,1,0, res_err=0, each res_valid one cycle after acceptance, taken_cnt=4.
- Load 001 (ET), request cond=3 with res_ready=0 for 5 cycles -> res_valid/res_taken=1 held stable; flag_ready=0 throughout; new flag_valid is not captured.
- In LOADED with flags 010 (LT), present flags 100 and request cond=4 in the same cycle -> res_taken=1 (old flags); next cond=2 request -> res_taken=1 (new flags).
- Load malformed 011 -> cond=0 gives res_err=1, taken=0; cond=6 gives taken=1, err=0. Then cond=9 on valid flags -> res_err=1.
- CNT_W=3: 9 taken results -> taken_cnt saturates at 7. cnt_clr coincident with a taken acceptance -> 0. Assert rst while BUSY -> res_valid=0 immediately, state EMPTY.
